// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and launch controller feeding the UART transmitter
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              uart_clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic              data_ready,
    output logic [7:0]        tx_data,
    input  logic              transmit_end,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, PRESENT, DRAIN} state_t;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              data_ready_q, data_ready_d;
    logic [7:0]        tx_data_q, tx_data_d;
    state_t            state_q, state_d;
    logic              push, drop, pop;

    // Storage is not reset; reset only discards it by clearing the pointers and level.
    always_ff @(posedge uart_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        push = wr_en && !full_q;
        drop = wr_en && full_q;
        // The UART pulling transmit_end low is its acceptance of the presented byte.
        pop  = (state_q == PRESENT) && !transmit_end;

        wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (ADDR_W+1)'(1);
        end
        full_d  = (level_d == (ADDR_W+1)'(DEPTH));
        empty_d = (level_d == '0);

        overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);

        state_d      = state_q;
        data_ready_d = data_ready_q;
        tx_data_d    = tx_data_q;
        case (state_q)
            IDLE: begin
                if (!empty_q && transmit_end) begin
                    tx_data_d    = mem_q[rd_ptr_q];
                    data_ready_d = 1'b1;
                    state_d      = PRESENT;
                end
            end
            PRESENT: begin
                if (!transmit_end) begin
                    data_ready_d = 1'b0;
                    state_d      = DRAIN;
                end
            end
            DRAIN: begin
                data_ready_d = 1'b0;
                if (transmit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                data_ready_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            overflow_q   <= 1'b0;
            data_ready_q <= 1'b0;
            tx_data_q    <= 8'h00;
            state_q      <= IDLE;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            overflow_q   <= overflow_d;
            data_ready_q <= data_ready_d;
            tx_data_q    <= tx_data_d;
            state_q      <= state_d;
        end
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign data_ready = data_ready_q;
    assign tx_data    = tx_data_q;
    assign busy       = (state_q != IDLE) || !empty_q;

endmodule
